// File: rtl/mppc_pkg.sv
// rtl/mppc_pkg.sv - shared constants and saturating counter helpers
// Purpose: default sizing constants for the MPPC coincidence/rate block and
//          the saturating-increment helpers every event counter uses.
// Ports:   none (package).
package mppc_pkg;

  localparam int N_CH_MAX        = 8;
  localparam int WINDOW_DEF      = 4;
  localparam int GATE_CYCLES_DEF = 12_000_000;
  localparam int CNT_W_DEF       = 24;

  // All-ones value of a w-bit counter, carried in 32 bits (w <= 32).
  function automatic logic [31:0] cnt_max(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Increment v by one unless it already sits at all-ones for width w.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input int w);
    if (inc && (v != cnt_max(w))) return v + 32'd1;
    return v;
  endfunction

  // True when an increment is requested but the counter is already full,
  // i.e. an event is being dropped.
  function automatic logic sat_hit(input logic [31:0] v, input logic inc, input int w);
    return inc && (v == cnt_max(w));
  endfunction

endpackage

// File: rtl/coinc_rate_counter_if.sv
// rtl/coinc_rate_counter_if.sv - channel input and count readout bundle
// Purpose: groups the enable/channel inputs and the pulse/snapshot outputs
//          of coinc_rate_counter.
// Ports (master = driver of channels/host side, slave = counter block):
//   enable, ch_in                        master -> slave
//   single_pulse, coinc_pulse,
//   singles_cnt, coinc_cnt, overflow,
//   cnt_valid                            slave -> master
interface coinc_rate_counter_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = mppc_pkg::CNT_W_DEF
) ();

  logic                    enable;
  logic [N_CH-1:0]         ch_in;
  logic [N_CH-1:0]         single_pulse;
  logic                    coinc_pulse;
  logic [N_CH*CNT_W-1:0]   singles_cnt;
  logic [CNT_W-1:0]        coinc_cnt;
  logic                    overflow;
  logic                    cnt_valid;

  modport master (
    output enable, ch_in,
    input  single_pulse, coinc_pulse, singles_cnt, coinc_cnt, overflow, cnt_valid
  );

  modport slave (
    input  enable, ch_in,
    output single_pulse, coinc_pulse, singles_cnt, coinc_cnt, overflow, cnt_valid
  );

endinterface

// File: rtl/chan_edge_window.sv
// rtl/chan_edge_window.sv - per-channel synchroniser, edge detect and window
// Purpose: brings one asynchronous discriminator level into clk, finds its
//          rising edges and stretches each into a WINDOW-cycle active window.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       low forces edge/window to 0 (synchroniser keeps sampling)
//   ch_in        raw asynchronous channel level
//   edge_o       one-cycle rising-edge strobe (combinational, gated by enable)
//   active_o     high while the window counter is non-zero
module chan_edge_window #(
  parameter int WINDOW = mppc_pkg::WINDOW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic ch_in,
  output logic edge_o,
  output logic active_o
);

  localparam logic [7:0] WLOAD = 8'(WINDOW);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [7:0] wcnt_q, wcnt_d;

  always_comb begin
    s1_d = ch_in;
    s2_d = s1_q;
    // s3 keeps tracking while disabled so a level already high when enable
    // rises is not mistaken for a new edge.
    s3_d = s2_q;

    edge_o   = enable & s2_q & ~s3_q;
    active_o = (wcnt_q != 8'd0);

    wcnt_d = wcnt_q;
    if (!enable) begin
      wcnt_d = 8'd0;
    end else if (edge_o) begin
      wcnt_d = WLOAD;
    end else if (wcnt_q != 8'd0) begin
      wcnt_d = wcnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      wcnt_q <= 8'd0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/coinc_rate_counter.sv
// rtl/coinc_rate_counter.sv - N-fold coincidence detector and gated rate counter
// Purpose: per-channel edge/window front ends, coincidence pulse generation,
//          saturating singles/coincidence counters and a gate timer that
//          publishes a latched snapshot once per gate.
// Ports:
//   CLK, RST_N   system clock, asynchronous active-low reset
//   bus          coinc_rate_counter_if.slave: enable, ch_in in;
//                single_pulse, coinc_pulse, singles_cnt (ch0 in LSBs),
//                coinc_cnt, overflow, cnt_valid out
module coinc_rate_counter
  import mppc_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  coinc_rate_counter_if.slave  bus
);

  localparam int             TW   = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]  LAST = TW'(GATE_CYCLES - 1);

  logic [N_CH-1:0]       ch_edge;
  logic [N_CH-1:0]       active_w;
  logic                  all_active;
  logic                  terminal;
  logic                  sat_now;
  logic [N_CH*CNT_W-1:0] singles_next;
  logic [CNT_W-1:0]      coinc_next;

  logic [N_CH-1:0]       single_pulse_q, single_pulse_d;
  logic                  coinc_pulse_q, coinc_pulse_d;
  logic                  all_active_dly_q, all_active_dly_d;
  logic [N_CH*CNT_W-1:0] live_singles_q, live_singles_d;
  logic [CNT_W-1:0]      live_coinc_q, live_coinc_d;
  logic                  sticky_q, sticky_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [N_CH*CNT_W-1:0] snap_singles_q, snap_singles_d;
  logic [CNT_W-1:0]      snap_coinc_q, snap_coinc_d;
  logic                  overflow_q, overflow_d;
  logic                  cnt_valid_q, cnt_valid_d;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      chan_edge_window #(.WINDOW(WINDOW)) u_ch (
        .clk      (CLK),
        .rst_n    (RST_N),
        .enable   (bus.enable),
        .ch_in    (bus.ch_in[g]),
        .edge_o   (ch_edge[g]),
        .active_o (active_w[g])
      );
    end
  endgenerate

  always_comb begin
    logic [31:0] t;
    t = 32'd0;

    all_active = &active_w;
    terminal   = bus.enable && (timer_q == LAST);

    single_pulse_d   = ch_edge;
    // Coincidence fires only on the rising edge of all_active, so retriggers
    // that keep every window open do not count again.
    all_active_dly_d = bus.enable & all_active;
    coinc_pulse_d    = bus.enable & all_active & ~all_active_dly_q;

    // Live value plus this cycle's increment, saturated.
    sat_now      = 1'b0;
    singles_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      t = sat_inc(32'(live_singles_q[i*CNT_W +: CNT_W]), single_pulse_q[i], CNT_W);
      singles_next[i*CNT_W +: CNT_W] = t[CNT_W-1:0];
      sat_now = sat_now | sat_hit(32'(live_singles_q[i*CNT_W +: CNT_W]), single_pulse_q[i], CNT_W);
    end
    t          = sat_inc(32'(live_coinc_q), coinc_pulse_q, CNT_W);
    coinc_next = t[CNT_W-1:0];
    sat_now    = sat_now | sat_hit(32'(live_coinc_q), coinc_pulse_q, CNT_W);

    live_singles_d = singles_next;
    live_coinc_d   = coinc_next;
    sticky_d       = sticky_q | sat_now;
    timer_d        = timer_q + TW'(1);
    snap_singles_d = snap_singles_q;
    snap_coinc_d   = snap_coinc_q;
    overflow_d     = overflow_q;
    cnt_valid_d    = 1'b0;

    if (!bus.enable) begin
      live_singles_d = '0;
      live_coinc_d   = '0;
      sticky_d       = 1'b0;
      timer_d        = '0;
    end else if (terminal) begin
      snap_singles_d = singles_next;
      snap_coinc_d   = coinc_next;
      overflow_d     = sticky_q | sat_now;
      live_singles_d = '0;
      live_coinc_d   = '0;
      sticky_d       = 1'b0;
      timer_d        = '0;
      cnt_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      single_pulse_q   <= '0;
      coinc_pulse_q    <= 1'b0;
      all_active_dly_q <= 1'b0;
      live_singles_q   <= '0;
      live_coinc_q     <= '0;
      sticky_q         <= 1'b0;
      timer_q          <= '0;
      snap_singles_q   <= '0;
      snap_coinc_q     <= '0;
      overflow_q       <= 1'b0;
      cnt_valid_q      <= 1'b0;
    end else begin
      single_pulse_q   <= single_pulse_d;
      coinc_pulse_q    <= coinc_pulse_d;
      all_active_dly_q <= all_active_dly_d;
      live_singles_q   <= live_singles_d;
      live_coinc_q     <= live_coinc_d;
      sticky_q         <= sticky_d;
      timer_q          <= timer_d;
      snap_singles_q   <= snap_singles_d;
      snap_coinc_q     <= snap_coinc_d;
      overflow_q       <= overflow_d;
      cnt_valid_q      <= cnt_valid_d;
    end
  end

  assign bus.single_pulse = single_pulse_q;
  assign bus.coinc_pulse  = coinc_pulse_q;
  assign bus.singles_cnt  = snap_singles_q;
  assign bus.coinc_cnt    = snap_coinc_q;
  assign bus.overflow     = overflow_q;
  assign bus.cnt_valid    = cnt_valid_q;

endmodule

// File: tb/tb_coinc_rate_counter.sv
// tb/tb_coinc_rate_counter.sv - self-checking bench for coinc_rate_counter
module tb_coinc_rate_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  coinc_rate_counter_if #(.N_CH(2), .CNT_W(24)) bus_a ();
  coinc_rate_counter_if #(.N_CH(2), .CNT_W(8))  bus_b ();

  coinc_rate_counter #(.N_CH(2), .WINDOW(4), .GATE_CYCLES(100), .CNT_W(24)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(bus_a)
  );
  coinc_rate_counter #(.N_CH(2), .WINDOW(4), .GATE_CYCLES(1000), .CNT_W(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] mk(input int s, input int p, input int n);
    logic [1023:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[s + j*p] = 1'b1;
    return r;
  endfunction

  typedef struct {
    string          name;
    logic [1023:0]  m0;
    logic [1023:0]  m1;
    int             ec;
    int             e0;
    int             e1;
    bit             lat;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [1023:0] m0, input logic [1023:0] m1,
                               input int ec, input int e0, input int e1, input bit lat);
    vec_t v;
    v.name = nm; v.m0 = m0; v.m1 = m1; v.ec = ec; v.e0 = e0; v.e1 = e1; v.lat = lat;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic en, input logic [1:0] ch);
    if (sel == 0) begin
      bus_a.enable = en; bus_a.ch_in = ch;
    end else begin
      bus_b.enable = en; bus_b.ch_in = ch;
    end
  endtask

  // Cycle c: inputs applied before posedge c, outputs observed after it.
  task automatic run(input int sel, input logic [1023:0] m0, input logic [1023:0] m1,
                     input int ncyc, input bit restart,
                     output int valid_at, output int nvalid, output int first_sp,
                     output int sp_val, output int first_cp, output int ncp, output int nsp);
    logic       v, cp;
    logic [1:0] sp;
    if (restart) begin
      for (int i = 0; i < 4; i++) begin
        drive(sel, 1'b0, 2'b00);
        step();
      end
    end
    valid_at = -1; nvalid = 0; first_sp = -1; sp_val = 0; first_cp = -1; ncp = 0; nsp = 0;
    for (int c = 0; c < ncyc; c++) begin
      drive(sel, 1'b1, {m1[c], m0[c]});
      step();
      if (sel == 0) begin
        v = bus_a.cnt_valid; cp = bus_a.coinc_pulse; sp = bus_a.single_pulse;
      end else begin
        v = bus_b.cnt_valid; cp = bus_b.coinc_pulse; sp = bus_b.single_pulse;
      end
      if (v) begin
        nvalid++;
        if (valid_at < 0) valid_at = c;
      end
      if (cp) begin
        ncp++;
        if (first_cp < 0) first_cp = c;
      end
      if (sp != 2'b00 && first_sp < 0) begin
        first_sp = c;
        sp_val = int'(sp);
      end
      nsp += int'(sp[0]) + int'(sp[1]);
    end
  endtask

  function automatic logic any_a();
    return |{bus_a.single_pulse, bus_a.coinc_pulse, bus_a.singles_cnt,
             bus_a.coinc_cnt, bus_a.overflow, bus_a.cnt_valid};
  endfunction

  function automatic logic any_b();
    return |{bus_b.single_pulse, bus_b.coinc_pulse, bus_b.singles_cnt,
             bus_b.coinc_cnt, bus_b.overflow, bus_b.cnt_valid};
  endfunction

  vec_t vecs[10];

  initial begin
    int va, nv, fsp, spv, fcp, ncp, nsp, nlow;

    vecs[0] = mkv("idle",      '0,          '0,          0, 0,  0,  1'b0);
    vecs[1] = mkv("simul",     mk(5,3,1),   mk(5,3,1),   1, 1,  1,  1'b1);
    vecs[2] = mkv("lag3",      mk(5,3,1),   mk(8,3,1),   1, 1,  1,  1'b0);
    vecs[3] = mkv("lag4",      mk(5,3,1),   mk(9,3,1),   0, 1,  1,  1'b0);
    vecs[4] = mkv("lead3",     mk(8,3,1),   mk(5,3,1),   1, 1,  1,  1'b0);
    vecs[5] = mkv("tog3",      mk(5,3,10),  mk(5,3,10),  1, 10, 10, 1'b0);
    vecs[6] = mkv("tog3_off",  mk(5,3,10),  mk(6,3,10),  1, 10, 10, 1'b0);
    vecs[7] = mkv("per4",      mk(5,4,5),   mk(5,4,5),   1, 5,  5,  1'b0);
    vecs[8] = mkv("per5",      mk(5,5,5),   mk(5,5,5),   5, 5,  5,  1'b0);
    vecs[9] = mkv("ch0_only",  mk(5,10,3),  '0,          0, 3,  0,  1'b0);

    rst_n = 1'b1;
    drive(0, 1'b0, 2'b00);
    drive(1, 1'b0, 2'b00);
    #2 rst_n = 1'b0;

    // Reset held with random channel activity.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 2'($urandom));
      drive(1, 1'b1, 2'($urandom));
      step();
      chk("reset_a_outputs", any_a(), 0);
      chk("reset_b_outputs", any_b(), 0);
    end
    drive(0, 1'b0, 2'b00);
    drive(1, 1'b0, 2'b00);
    step();
    rst_n = 1'b1;

    // Table-driven single-gate vectors on the 100-cycle instance.
    for (int k = 0; k < 10; k++) begin
      run(0, vecs[k].m0, vecs[k].m1, 100, 1'b1, va, nv, fsp, spv, fcp, ncp, nsp);
      chk({vecs[k].name, "_valid_at"},  va, 99);
      chk({vecs[k].name, "_nvalid"},    nv, 1);
      chk({vecs[k].name, "_coinc_cnt"}, bus_a.coinc_cnt, vecs[k].ec);
      chk({vecs[k].name, "_singles0"},  bus_a.singles_cnt[23:0], vecs[k].e0);
      chk({vecs[k].name, "_singles1"},  bus_a.singles_cnt[47:24], vecs[k].e1);
      chk({vecs[k].name, "_overflow"},  bus_a.overflow, 0);
      chk({vecs[k].name, "_coinc_pulses"},  ncp, vecs[k].ec);
      chk({vecs[k].name, "_single_pulses"}, nsp, vecs[k].e0 + vecs[k].e1);
      if (vecs[k].lat) begin
        chk({vecs[k].name, "_single_lat"}, fsp, 7);
        chk({vecs[k].name, "_single_val"}, spv, 3);
        chk({vecs[k].name, "_coinc_lat"},  fcp, 8);
      end
    end

    // Coincidences spread over the gate, the last one in the terminal cycle.
    run(0, mk(6,1,1) | mk(46,1,1) | mk(95,1,1), mk(6,1,1) | mk(46,1,1) | mk(95,1,1),
        100, 1'b1, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("spread_valid_at",  va, 99);
    chk("spread_coinc_cnt", bus_a.coinc_cnt, 3);
    chk("spread_singles0",  bus_a.singles_cnt[23:0], 3);
    // Next gate back to back: valid again 100 cycles later, counts cleared.
    run(0, '0, '0, 100, 1'b0, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("spread2_valid_at",  va, 99);
    chk("spread2_nvalid",    nv, 1);
    chk("spread2_coinc_cnt", bus_a.coinc_cnt, 0);
    chk("spread2_singles0",  bus_a.singles_cnt[23:0], 0);

    // 8-bit counters: 300 edges saturate at 255 and flag overflow.
    run(1, mk(5,3,300), '0, 1000, 1'b1, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("sat_valid_at",  va, 999);
    chk("sat_singles0",  bus_b.singles_cnt[7:0], 255);
    chk("sat_singles1",  bus_b.singles_cnt[15:8], 0);
    chk("sat_coinc_cnt", bus_b.coinc_cnt, 0);
    chk("sat_overflow",  bus_b.overflow, 1);

    // Enable dropped mid-gate: no publish, snapshot holds, gate restarts.
    run(1, mk(5,3,10), '0, 500, 1'b1, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("drop_partial_nvalid", nv, 0);
    nlow = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1, 1'b0, 2'b00);
      step();
      if (bus_b.cnt_valid || bus_b.coinc_pulse) nlow++;
    end
    chk("drop_low_pulses",     nlow, 0);
    chk("drop_hold_singles0",  bus_b.singles_cnt[7:0], 255);
    chk("drop_hold_overflow",  bus_b.overflow, 1);
    run(1, mk(5,3,5), '0, 1000, 1'b0, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("restart_valid_at", va, 999);
    chk("restart_nvalid",   nv, 1);
    chk("restart_singles0", bus_b.singles_cnt[7:0], 5);
    chk("restart_overflow", bus_b.overflow, 0);

    // Reset mid-gate clears outputs at once and publishes nothing.
    run(1, mk(5,3,5), '0, 300, 1'b0, va, nv, fsp, spv, fcp, ncp, nsp);
    rst_n = 1'b0;
    #1;
    chk("midrst_b_singles", bus_b.singles_cnt, 0);
    chk("midrst_b_outputs", any_b(), 0);
    chk("midrst_a_outputs", any_a(), 0);
    step();
    rst_n = 1'b1;
    run(1, '0, '0, 1000, 1'b1, va, nv, fsp, spv, fcp, ncp, nsp);
    chk("quiet_valid_at", va, 999);
    chk("quiet_nvalid",   nv, 1);
    chk("quiet_singles0", bus_b.singles_cnt[7:0], 0);
    chk("quiet_overflow", bus_b.overflow, 0);
    chk("quiet_pulses",   nsp + ncp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coinc_rate_counter.md
# coinc_rate_counter

Downstream consumer of the conditioned MPPC channel inputs (post boot-discharge, `SB_IO` `D_IN_0`). It synchronises each asynchronous discriminator channel, detects rising edges, and stretches each edge into a fixed coincidence window. It emits a one-cycle pulse per N-fold coincidence and accumulates per-channel singles and coincidence counts over a fixed gate. At gate end it publishes a latched snapshot for the GPIO/host readout path.

## Interface
- `N_CH`, 2: number of channels in the coincidence (2..8); all must overlap.
- `WINDOW`, 4: window length in `CLK` cycles per edge (1..255).
- `GATE_CYCLES`, 12_000_000: gate length in cycles (1 s at 12 MHz); ≥2.
- `CNT_W`, 24: width of every counter and snapshot.
- `CLK`  in  1  system clock.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  driven by the boot-done flag; low holds block idle.
- `ch_in`  in  N_CH  raw channel levels, asynchronous to `CLK`.
- `single_pulse`  out  N_CH  one-cycle pulse per detected rising edge.
- `coinc_pulse`  out  1  one-cycle pulse per coincidence.
- `singles_cnt`  out  N_CH*CNT_W  latched singles per channel, ch0 in LSBs.
- `coinc_cnt`  out  CNT_W  latched coincidence count.
- `overflow`  out  1  latched: some counter saturated in the last gate.
- `cnt_valid`  out  1  one-cycle pulse when the snapshot updates.

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`), then history FF `s3`. `edge = s2 & ~s3`.
- Window counter: loads `WINDOW` on `edge` (retrigger allowed). Otherwise it decrements to 0. `active = (wcnt != 0)`.
- `all_active = &active`. `coinc_pulse <= all_active & ~all_active_d`. At most one coincidence is counted per continuous all-active interval, and retriggers inside it do not recount.
- Live counters increment on `single_pulse[i]` and on `coinc_pulse`. They saturate at all-ones, and saturation sets the live sticky overflow.
- Gate timer runs 0..GATE_CYCLES-1 while `enable` is high. Actions on the terminal cycle:
  - snapshot = live value + that cycle's increment (saturated).
  - `overflow` is latched from the live sticky, including saturation on that cycle.
  - live counters and sticky clear to 0.
  - `cnt_valid` pulses.
- `enable` low: synchronisers keep sampling. Edge detection, window counters, live counters and gate timer are forced to 0, and no pulses are emitted. Snapshot outputs hold their last values. When `enable` rises, a full new gate starts at timer 0.
- Reset (`RST_N` low, any time including mid-gate): all flops and outputs go to 0 immediately. No partial snapshot is published.

## Timing
- Let k be the first `CLK` edge sampling `ch_in[i]` high. `s2` is high after k+1. `single_pulse[i]` is high during the cycle after k+2, and `active` is high after k+2 for exactly `WINDOW` cycles with no retrigger.
- `coinc_pulse` rises after k+3 for simultaneous inputs, i.e. 3-cycle latency. Width is 1 cycle.
- Two channels with edges at k and j (j ≥ k) coincide iff `j − k ≤ WINDOW − 1`.
- Input high pulses shorter than 1 cycle may be missed. Edges closer than 2 cycles on one channel may merge.
- `cnt_valid` and new snapshot values appear together, after the edge that ends cycle `GATE_CYCLES−1` of the gate. A `cnt_valid` pulse is followed by the next one exactly `GATE_CYCLES` cycles later.

## Structure
- Shared package `mppc_pkg`:
  - default constants `WINDOW_DEF`, `GATE_CYCLES_DEF`, `CNT_W_DEF`, `N_CH_MAX = 8`.
  - a saturating-increment function used by all counters.
- Sub-module `chan_edge_window`: synchroniser, edge detector and window counter for one channel. Instantiated `N_CH` times via generate. The top level holds the AND/edge logic, counters, gate timer and snapshot.

## Test plan
- Reset: hold `RST_N` low with random `ch_in` → all outputs 0. Release with `ch_in` idle → no pulses and `cnt_valid` at cycle `GATE_CYCLES−1`, with all counts 0.
- Simultaneous rise of ch0 and ch1 (WINDOW=4) → `single_pulse`=2'b11 after k+2, `coinc_pulse` after k+3. At gate end `coinc_cnt`=1 and singles=1,1.
- ch1 rises 3 cycles after ch0 → one coincidence. ch1 rises 4 cycles after ch0 → none, with singles still 1,1.
- Both channels toggle every 3 cycles for 30 cycles, so windows stay overlapped → `coinc_cnt`=1 and singles=10 each.
- GATE_CYCLES=100, coincidences injected at cycles 10, 50 and 99 → `coinc_cnt`=3 in the first snapshot. The next snapshot is 0 and `cnt_valid` is spaced 100 cycles apart.
- CNT_W=8, 300 ch0 edges in one gate → `singles_cnt[0]`=255 and `overflow`=1. The next quiet gate gives `overflow`=0. Dropping `enable` mid-gate produces no `cnt_valid`, and the gate restarts from 0 when `enable` rises.
